// File: rtl/stream_demux_pkg.sv
// Shared constants and channel state type for the stream_demux block.
package stream_demux_pkg;

    localparam int unsigned W_DEF = 8;
    localparam int unsigned N_DEF = 4;

    typedef enum logic {
        EMPTY,
        FULL
    } chan_state_t;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry registered holding buffer for a single output channel.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    chan_state_t  state_q;
    logic [W-1:0] data_q;

    // A full slot can take a new word in the same cycle its consumer drains it.
    assign ready_o = (state_q == EMPTY) || ready_i;
    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (load_i) begin
                        state_q <= FULL;
                        data_q  <= data_i;
                    end
                end
                FULL: begin
                    if (load_i) begin
                        data_q <= data_i;
                    end else if (ready_i) begin
                        state_q <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demultiplexer with a registered buffer per channel.
// Define STREAM_DEMUX_SEL_ERR_EN to accept and drop out-of-range selects and flag them on err.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned N  = N_DEF,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SW-1:0]  in_sel,
    input  logic [W-1:0]   in_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data
`ifdef STREAM_DEMUX_SEL_ERR_EN
    ,
    output logic           err
`endif
);

    logic [N-1:0] slot_ready;
    logic         sel_ok;
    logic         sel_miss_ready;

    assign sel_ok = (32'(in_sel) < N);

`ifdef STREAM_DEMUX_SEL_ERR_EN
    // Out-of-range words are swallowed so the producer never deadlocks.
    assign sel_miss_ready = 1'b1;
`else
    assign sel_miss_ready = 1'b0;
`endif

    assign in_ready = sel_ok ? slot_ready[in_sel] : sel_miss_ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        logic load;

        assign load = in_valid && sel_ok && slot_ready[i] && (in_sel == SW'(i));

        stream_demux_slot #(
            .W(W)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load),
            .data_i (in_data),
            .ready_i(out_ready[i]),
            .ready_o(slot_ready[i]),
            .valid_o(out_valid[i]),
            .data_o (out_data[i*W +: W])
        );
    end

`ifdef STREAM_DEMUX_SEL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_valid && !sel_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: N=4 main instance plus an N=3 instance for bad selects.
module tb_stream_demux;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;

    logic        in3_valid;
    logic        in3_ready;
    logic [1:0]  in3_sel;
    logic [7:0]  in3_data;
    logic [2:0]  out3_valid;
    logic [2:0]  out3_ready;
    logic [23:0] out3_data;
`ifdef STREAM_DEMUX_SEL_ERR_EN
    logic        err;
    logic        err3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[4][$];

    stream_demux #(
        .W(8),
        .N(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef STREAM_DEMUX_SEL_ERR_EN
        ,
        .err      (err)
`endif
    );

    stream_demux #(
        .W(8),
        .N(3)
    ) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in3_valid),
        .in_ready (in3_ready),
        .in_sel   (in3_sel),
        .in_data  (in3_data),
        .out_valid(out3_valid),
        .out_ready(out3_ready),
        .out_data (out3_data)
`ifdef STREAM_DEMUX_SEL_ERR_EN
        ,
        .err      (err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a cycle; queue it when acceptance is expected.
    task automatic send(input int sel, input logic [7:0] d, input logic exp_ready);
        in_valid = 1'b1;
        in_sel   = 2'(sel);
        in_data  = d;
        #2;
        check($sformatf("in_ready sel%0d data %h", sel, d), {31'b0, in_ready}, {31'b0, exp_ready});
        if (exp_ready) sb[sel].push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every output transfer that will happen at the next edge is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected ch%0d: got %h, required no word", i,
                                 out_data[i*8 +: 8]);
                    end else begin
                        check($sformatf("ch%0d data", i), {24'b0, out_data[i*8 +: 8]},
                              {24'b0, sb[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 8'hFF;
        out_ready = 4'h0;
        in3_valid = 1'b0;
        in3_sel   = 2'd0;
        in3_data  = 8'h00;
        out3_ready = 3'b000;

        // Reset held with in_valid asserted: nothing may be captured.
        repeat (3) tick();
        check("reset out_valid", {28'b0, out_valid}, 32'h0);
        check("reset out_data", out_data, 32'h0);
        check("reset out3_valid", {29'b0, out3_valid}, 32'h0);
`ifdef STREAM_DEMUX_SEL_ERR_EN
        check("reset err", {31'b0, err}, 32'h0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("idle in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        check("post-reset out_valid", {28'b0, out_valid}, 32'h0);

        // Routing: one word per channel on consecutive cycles.
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            send(i, 8'hA0 + 8'(i), 1'b1);
            check($sformatf("route out_valid sel%0d", i), {28'b0, out_valid}, 32'(1 << i));
        end
        tick();
        check("route drained", {28'b0, out_valid}, 32'h0);

        // Backpressure on channel 2.
        out_ready = 4'b1011;
        send(2, 8'h55, 1'b1);
        check("bp out_valid", {28'b0, out_valid}, 32'h4);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h66;
        #2;
        check("bp stalled in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        tick();
        check("bp hold data", {24'b0, out_data[23:16]}, 32'h55);
        check("bp still stalled", {31'b0, in_ready}, 32'h0);
        out_ready = 4'hF;
        #1;
        check("bp release in_ready", {31'b0, in_ready}, 32'h1);
        sb[2].push_back(8'h66);
        tick();
        in_valid = 1'b0;
        check("bp replace valid", {28'b0, out_valid}, 32'h4);
        check("bp replace data", {24'b0, out_data[23:16]}, 32'h66);
        tick();
        check("bp drained", {28'b0, out_valid}, 32'h0);

        // Independence: channel 1 stalled full, channel 3 still loads.
        out_ready = 4'h0;
        send(1, 8'h11, 1'b1);
        send(3, 8'h77, 1'b1);
        check("indep out_valid", {28'b0, out_valid}, 32'hA);
        check("indep ch1 data", {24'b0, out_data[15:8]}, 32'h11);
        check("indep ch3 data", {24'b0, out_data[31:24]}, 32'h77);
        out_ready = 4'hF;
        tick();
        check("indep drained", {28'b0, out_valid}, 32'h0);

        // Throughput: 16 back-to-back words to channel 0.
        for (int k = 0; k < 16; k++) begin
            send(0, 8'(k), 1'b1);
            check($sformatf("tput valid %0d", k), {31'b0, out_valid[0]}, 32'h1);
        end
        tick();
        check("tput drained", {28'b0, out_valid}, 32'h0);

        // Asynchronous reset mid-stream discards the buffered word.
        out_ready = 4'h0;
        send(2, 8'h99, 1'b1);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) sb[i].delete();
        #1;
        check("async reset out_valid", {28'b0, out_valid}, 32'h0);
        check("async reset out_data", out_data, 32'h0);
        out_ready = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("after reset nothing delivered", {28'b0, out_valid}, 32'h0);

        // Bad select on the N=3 instance.
        in3_valid = 1'b1;
        in3_sel   = 2'd1;
        in3_data  = 8'h42;
        tick();
        in3_valid = 1'b0;
        check("n3 load ch1", {29'b0, out3_valid}, 32'h2);
        in3_valid = 1'b1;
        in3_sel   = 2'd3;
        in3_data  = 8'hEE;
        #2;
`ifdef STREAM_DEMUX_SEL_ERR_EN
        check("n3 bad sel in_ready", {31'b0, in3_ready}, 32'h1);
        check("n3 err before", {31'b0, err3}, 32'h0);
`else
        check("n3 bad sel in_ready", {31'b0, in3_ready}, 32'h0);
`endif
        tick();
        in3_valid = 1'b0;
        check("n3 out_valid unchanged", {29'b0, out3_valid}, 32'h2);
        check("n3 out_data unchanged", {8'b0, out3_data}, 32'h004200);
`ifdef STREAM_DEMUX_SEL_ERR_EN
        check("n3 err set", {31'b0, err3}, 32'h1);
        tick();
        check("n3 err sticky", {31'b0, err3}, 32'h1);
        check("n4 err clear", {31'b0, err}, 32'h0);
`else
        tick();
        check("n3 still unchanged", {29'b0, out3_valid}, 32'h2);
`endif

        for (int i = 0; i < 4; i++) begin
            check($sformatf("ch%0d scoreboard empty", i), 32'(sb[i].size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-N streaming demultiplexer with valid/ready handshake; the inverse of the 2-to-1 mux primitive.
- Routes each accepted input word to the output channel chosen by `in_sel`.
- Each channel has a one-entry registered holding buffer, so channels drain independently and outputs are glitch-free.
- Sits between a single producer and N independent consumers in the combinational/sequential exercise set.

Parameters:
- W, 8, data width in bits.
- N, 4, number of output channels (N >= 2; need not be a power of two).
- SW, $clog2(N), width of `in_sel`; derived, not overridden.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, producer presents a word.
- in_ready, output, 1, block can accept the word this cycle.
- in_sel, input, SW, destination channel index; sampled with the word.
- in_data, input, W, word to route.
- out_valid, output, N, bit i set = channel i buffer holds a word.
- out_ready, input, N, bit i set = consumer i takes the word this cycle.
- out_data, output, N*W, channel i word in bits [i*W +: W].

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0. in_ready is combinational and follows from the empty buffers.
- Reset mid-operation discards all buffered words; nothing is delivered after reset.
- Input handshake: a transfer occurs on a rising edge with in_valid & in_ready.
- in_ready = !out_valid[in_sel] | out_ready[in_sel], for in-range in_sel. This is combinational from in_sel, out_valid and out_ready.
- in_ready never depends on in_valid.
- Out-of-range in_sel (>= N): behaviour is set by the optional feature below.
- Output handshake: channel i transfers when out_valid[i] & out_ready[i].
  - On transfer with no new load, out_valid[i] clears next cycle.
- Latency: a word accepted at edge k appears on out_data[i] with out_valid[i] = 1 after edge k, i.e. 1 cycle.
- Simultaneous drain and load on the same channel in the same cycle:
  - The new word replaces the old one.
  - out_valid[i] stays 1.
  - Full throughput of 1 word/cycle on a single channel.
- Loads to channel j do not disturb channel i != j. Any number of channels may drain in the same cycle.
- out_data[i] holds its value while out_valid[i] = 1 and out_ready[i] = 0. It is not modified except by a load.
- in_data and in_sel may change arbitrarily while in_valid = 0 without effect.
- Per-channel state machine, states EMPTY and FULL:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load or on stall.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: STREAM_DEMUX_SEL_ERR_EN.
- Defined:
  - Extra port `err`, output, 1, reset 0.
  - A word with in_sel >= N is accepted (in_ready = 1) and dropped.
  - `err` sets on the accept edge and is sticky until reset.
- Undefined:
  - No `err` port.
  - in_sel >= N forces in_ready = 0 (the producer stalls). No state changes.
- When N is a power of two the feature has no observable effect except `err` staying 0.

Decomposition:
- Package stream_demux_pkg:
  - Default constants W_DEF = 8 and N_DEF = 4.
  - typedef chan_state_t enum {EMPTY, FULL}.
- Natural sub-module: stream_demux_slot, one per channel via generate. It holds one word with load/drain handshake and exposes valid/ready/data.
- The top level contains only select decode, in_ready mux and err logic.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0000, out_data = 0, no acceptance. Assert rst_n = 0 asynchronously mid-stream → out_valid = 0 immediately.
- Routing: out_ready = 1111; send 8'hA0, A1, A2, A3 with in_sel = 0, 1, 2, 3 on consecutive cycles → each word appears one cycle later only on the matching channel; in_ready stays 1.
- Backpressure: out_ready[2] = 0; send 8'h55 then 8'h66 to sel 2:
  - 8'h55 held on out_data[2].
  - in_ready = 0 for the second word.
  - Raising out_ready[2] gives same-cycle acceptance; 8'h66 is next on channel 2.
- Independence: channel 1 stalled and full; send 8'h77 to sel 3 → accepted; out_valid = 1010; channel 1 data unchanged.
- Throughput: out_ready[0] = 1; stream 16 words 0..15 to sel 0 back-to-back → in_ready = 1 every cycle; channel 0 outputs 0..15 in order, no bubbles.
- Bad select with N = 3, in_sel = 3, in_valid = 1:
  - Macro defined: accepted, err = 1 next cycle and stays 1, out_valid unchanged.
  - Macro undefined: in_ready = 0, nothing changes.
